// File: rtl/mini_mips_pkg.sv
// Shared encodings for the MiniMIPS multi-cycle controller: opcodes, ALUop, mux selects, states.
// The ALUop codes are also consumed by ALU_control.
package mini_mips_pkg;

    localparam int OP_W     = 4;
    localparam int ALU_OP_W = 2;

    localparam logic [OP_W-1:0] OP_R    = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADDI = 4'b0001;
    localparam logic [OP_W-1:0] OP_LW   = 4'b0100;
    localparam logic [OP_W-1:0] OP_SW   = 4'b0101;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'b0110;
    localparam logic [OP_W-1:0] OP_BNE  = 4'b0111;
    localparam logic [OP_W-1:0] OP_J    = 4'b1000;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_R_WB, ST_EXEC_I, ST_I_WB,
        ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR, ST_BRANCH, ST_JUMP, ST_TRAP
    } state_e;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src_a;
        logic [1:0]          alu_src_b;
        logic [1:0]          pc_src;
        logic                pc_write;
        logic                mem_req;
        logic                mem_we;
        logic                i_or_d;
        logic                reg_write;
        logic                reg_dst;
        logic                mem_to_reg;
        logic                instr_done;
    } ctrl_t;

    // State-only (Moore) part of the control word; input-dependent strobes are added in the top.
    function automatic ctrl_t moore_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = SRCB_ONE;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PC_ALU;
            end
            ST_DECODE:   c.alu_src_b = SRCB_BOFF;
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALU_RTYPE;
            end
            ST_R_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            ST_I_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_MEM_RD: begin
                c.mem_req = 1'b1;
                c.i_or_d  = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.i_or_d  = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_RT;
                c.alu_op     = ALU_SUB;
                c.pc_src     = PC_ALUOUT;
                c.instr_done = 1'b1;
            end
            ST_JUMP: begin
                c.pc_src     = PC_JUMP;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mini_mips_op_decode.sv
// Combinational opcode classifier for the MiniMIPS controller.
module mini_mips_op_decode
    import mini_mips_pkg::*;
#(
    parameter int OPCODE_W = OP_W
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic                is_r_o,
    output logic                is_addi_o,
    output logic                is_lw_o,
    output logic                is_sw_o,
    output logic                is_beq_o,
    output logic                is_bne_o,
    output logic                is_j_o,
    output logic                is_illegal_o
);

    assign is_r_o    = (opcode_i == OPCODE_W'(OP_R));
    assign is_addi_o = (opcode_i == OPCODE_W'(OP_ADDI));
    assign is_lw_o   = (opcode_i == OPCODE_W'(OP_LW));
    assign is_sw_o   = (opcode_i == OPCODE_W'(OP_SW));
    assign is_beq_o  = (opcode_i == OPCODE_W'(OP_BEQ));
    assign is_bne_o  = (opcode_i == OPCODE_W'(OP_BNE));
    assign is_j_o    = (opcode_i == OPCODE_W'(OP_J));

    assign is_illegal_o = ~(is_r_o | is_addi_o | is_lw_o | is_sw_o |
                            is_beq_o | is_bne_o | is_j_o);

endmodule

// File: rtl/mini_mips_multicycle_ctrl.sv
// Multi-cycle main control FSM for MiniMIPS with registered Moore outputs plus Mealy handshake strobes.
// Define MINIMIPS_ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they execute as NOPs.
module mini_mips_multicycle_ctrl
    import mini_mips_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [ALUOP_W-1:0]  ALUop,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_src,
    output logic                pc_write,
    output logic                ir_write,
    output logic                mem_req,
    output logic                mem_we,
    output logic                i_or_d,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                instr_done,
    output logic                illegal_op
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    logic   is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_illegal;

    mini_mips_op_decode #(.OPCODE_W(OPCODE_W)) u_op_decode (
        .opcode_i     (opcode),
        .is_r_o       (is_r),
        .is_addi_o    (is_addi),
        .is_lw_o      (is_lw),
        .is_sw_o      (is_sw),
        .is_beq_o     (is_beq),
        .is_bne_o     (is_bne),
        .is_j_o       (is_j),
        .is_illegal_o (is_illegal)
    );

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (is_r)                 state_d = ST_EXEC_R;
                else if (is_addi)         state_d = ST_EXEC_I;
                else if (is_lw || is_sw)  state_d = ST_MEM_ADDR;
                else if (is_beq || is_bne) state_d = ST_BRANCH;
                else if (is_j)            state_d = ST_JUMP;
`ifdef MINIMIPS_ILLEGAL_TRAP_EN
                else                      state_d = ST_TRAP;
`else
                else                      state_d = ST_FETCH;
`endif
            end
            ST_EXEC_R:   state_d = ST_R_WB;
            ST_EXEC_I:   state_d = ST_I_WB;
            ST_MEM_ADDR: state_d = is_lw ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
            ST_R_WB, ST_I_WB, ST_MEM_WB, ST_BRANCH, ST_JUMP:
                         state_d = ST_FETCH;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            ctrl_q  <= moore_ctrl(state_d);
        end
    end

    logic fetch_hs, branch_take, wr_done, nop_done;

    assign fetch_hs    = (state_q == ST_FETCH) && mem_ready;
    assign branch_take = (state_q == ST_BRANCH) && ((is_beq && zero) || (is_bne && !zero));
    assign wr_done     = (state_q == ST_MEM_WR) && mem_ready;

`ifdef MINIMIPS_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_q | ((state_q == ST_DECODE) && is_illegal);
    end

    assign illegal_op = illegal_q;
    assign nop_done   = 1'b0;
`else
    assign illegal_op = 1'b0;
    assign nop_done   = (state_q == ST_DECODE) && is_illegal;
`endif

    assign ALUop      = ALUOP_W'(ctrl_q.alu_op);
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign pc_src     = ctrl_q.pc_src;
    assign pc_write   = ctrl_q.pc_write | fetch_hs | branch_take;
    assign ir_write   = fetch_hs;
    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign i_or_d     = ctrl_q.i_or_d;
    assign reg_write  = ctrl_q.reg_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign instr_done = ctrl_q.instr_done | wr_done | nop_done;

endmodule

// File: tb/tb_mini_mips_multicycle_ctrl.sv
// Directed bench for mini_mips_multicycle_ctrl; compares the full output word once per cycle.
// Honours MINIMIPS_ILLEGAL_TRAP_EN for the illegal-opcode scenario.
module tb_mini_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'b0000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic [1:0] ALUop, alu_src_b, pc_src;
    logic alu_src_a, pc_write, ir_write, mem_req, mem_we, i_or_d;
    logic reg_write, reg_dst, mem_to_reg, instr_done, illegal_op;

    mini_mips_multicycle_ctrl #(.OPCODE_W(4), .ALUOP_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ALUop      (ALUop),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .i_or_d     (i_or_d),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // {ALUop, src_a, src_b, pc_src, pc_write, ir_write, mem_req, mem_we, i_or_d,
    //  reg_write, reg_dst, mem_to_reg, instr_done, illegal_op}
    logic [16:0] obs;
    assign obs = {ALUop, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, mem_req, mem_we,
                  i_or_d, reg_write, reg_dst, mem_to_reg, instr_done, illegal_op};

    localparam logic [16:0] E_IDLE     = 17'b00_0_00_00_0_0_0_0_0_0_0_0_0_0;
    localparam logic [16:0] E_FETCH_W  = 17'b00_0_01_00_0_0_1_0_0_0_0_0_0_0;
    localparam logic [16:0] E_FETCH_R  = 17'b00_0_01_00_1_1_1_0_0_0_0_0_0_0;
    localparam logic [16:0] E_DECODE   = 17'b00_0_11_00_0_0_0_0_0_0_0_0_0_0;
    localparam logic [16:0] E_DEC_NOP  = 17'b00_0_11_00_0_0_0_0_0_0_0_0_1_0;
    localparam logic [16:0] E_EXEC_R   = 17'b10_1_00_00_0_0_0_0_0_0_0_0_0_0;
    localparam logic [16:0] E_R_WB     = 17'b00_0_00_00_0_0_0_0_0_1_1_0_1_0;
    localparam logic [16:0] E_EXEC_I   = 17'b00_1_10_00_0_0_0_0_0_0_0_0_0_0;
    localparam logic [16:0] E_I_WB     = 17'b00_0_00_00_0_0_0_0_0_1_0_0_1_0;
    localparam logic [16:0] E_MEM_RD   = 17'b00_0_00_00_0_0_1_0_1_0_0_0_0_0;
    localparam logic [16:0] E_MEM_WB   = 17'b00_0_00_00_0_0_0_0_0_1_0_1_1_0;
    localparam logic [16:0] E_MEM_WR_W = 17'b00_0_00_00_0_0_1_1_1_0_0_0_0_0;
    localparam logic [16:0] E_MEM_WR_R = 17'b00_0_00_00_0_0_1_1_1_0_0_0_1_0;
    localparam logic [16:0] E_BR_T     = 17'b01_1_00_01_1_0_0_0_0_0_0_0_1_0;
    localparam logic [16:0] E_BR_N     = 17'b01_1_00_01_0_0_0_0_0_0_0_0_1_0;
    localparam logic [16:0] E_JUMP     = 17'b00_0_00_10_1_0_0_0_0_0_0_0_1_0;
    localparam logic [16:0] E_TRAP     = 17'b00_0_00_00_0_0_0_0_0_0_0_0_0_1;

    int n_tests = 0;
    int n_fail  = 0;

    // Advance one clock: drive this cycle's inputs just after the edge, return at the falling edge.
    task automatic cycle(input logic rdy, input logic z);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        zero      = z;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", obs, E_IDLE);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected %b", obs, E_IDLE);
        end
    endtask

    task automatic test_rtype;
        logic [16:0] exp_v [8];
        exp_v = '{E_FETCH_R, E_DECODE, E_EXEC_R, E_R_WB, E_FETCH_R, E_DECODE, E_EXEC_R, E_R_WB};
        opcode = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0);
            n_tests++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL rtype cyc%0d: got %b expected %b", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_addi;
        logic [16:0] exp_v [4];
        exp_v = '{E_FETCH_R, E_DECODE, E_EXEC_I, E_I_WB};
        opcode = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0);
            n_tests++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL addi cyc%0d: got %b expected %b", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_lw_wait;
        logic [16:0] exp_v [7];
        logic        rdy_v [7];
        exp_v = '{E_FETCH_R, E_DECODE, E_EXEC_I, E_MEM_RD, E_MEM_RD, E_MEM_RD, E_MEM_WB};
        rdy_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 4'b0100;
        for (int i = 0; i < 7; i++) begin
            cycle(rdy_v[i], 1'b0);
            n_tests++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL lw cyc%0d: got %b expected %b", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_sw;
        logic [16:0] exp_v [5];
        logic        rdy_v [5];
        exp_v = '{E_FETCH_R, E_DECODE, E_EXEC_I, E_MEM_WR_W, E_MEM_WR_R};
        rdy_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        opcode = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            cycle(rdy_v[i], 1'b0);
            n_tests++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL sw cyc%0d: got %b expected %b", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_branch;
        logic [3:0]  op_v  [4];
        logic        z_v   [4];
        logic [16:0] br_v  [4];
        logic [16:0] exp_v [3];
        op_v = '{4'b0110, 4'b0110, 4'b0111, 4'b0111};
        z_v  = '{1'b1, 1'b0, 1'b1, 1'b0};
        br_v = '{E_BR_T, E_BR_N, E_BR_N, E_BR_T};
        for (int k = 0; k < 4; k++) begin
            opcode = op_v[k];
            exp_v  = '{E_FETCH_R, E_DECODE, br_v[k]};
            for (int i = 0; i < 3; i++) begin
                cycle(1'b1, z_v[k]);
                n_tests++;
                if (obs !== exp_v[i]) begin
                    n_fail++;
                    $display("FAIL branch op%b z%b cyc%0d: got %b expected %b",
                             op_v[k], z_v[k], i, obs, exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_jump;
        logic [16:0] exp_v [3];
        exp_v = '{E_FETCH_R, E_DECODE, E_JUMP};
        opcode = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            n_tests++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL jump cyc%0d: got %b expected %b", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fetch;
        logic [16:0] exp_v [4];
        exp_v = '{E_FETCH_R, E_DECODE, E_EXEC_R, E_R_WB};
        opcode = 4'b0000;
        cycle(1'b0, 1'b0);
        n_tests++;
        if (obs !== E_FETCH_W) begin
            n_fail++;
            $display("FAIL fetch_wait: got %b expected %b", obs, E_FETCH_W);
        end
        @(posedge clk);
        #3;
        n_tests++;
        if (obs !== E_FETCH_W) begin
            n_fail++;
            $display("FAIL fetch_wait_hold: got %b expected %b", obs, E_FETCH_W);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL async_reset_drop: got %b expected %b", obs, E_IDLE);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL restart_idle: got %b expected %b", obs, E_IDLE);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0);
            n_tests++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL restart cyc%0d: got %b expected %b", i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_illegal;
        opcode = 4'b1111;
        cycle(1'b1, 1'b0);
        n_tests++;
        if (obs !== E_FETCH_R) begin
            n_fail++;
            $display("FAIL illegal_fetch: got %b expected %b", obs, E_FETCH_R);
        end
        cycle(1'b1, 1'b0);
`ifdef MINIMIPS_ILLEGAL_TRAP_EN
        n_tests++;
        if (obs !== E_DECODE) begin
            n_fail++;
            $display("FAIL illegal_decode: got %b expected %b", obs, E_DECODE);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1);
            n_tests++;
            if (obs !== E_TRAP) begin
                n_fail++;
                $display("FAIL trap cyc%0d: got %b expected %b", i, obs, E_TRAP);
            end
        end
`else
        n_tests++;
        if (obs !== E_DEC_NOP) begin
            n_fail++;
            $display("FAIL illegal_decode_nop: got %b expected %b", obs, E_DEC_NOP);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0);
            n_tests++;
            if (obs !== ((i % 2 == 0) ? E_FETCH_R : E_DEC_NOP)) begin
                n_fail++;
                $display("FAIL nop_follow cyc%0d: got %b expected %b", i, obs,
                         (i % 2 == 0) ? E_FETCH_R : E_DEC_NOP);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_addi();
        test_lw_wait();
        test_sw();
        test_branch();
        test_jump();
        test_reset_mid_fetch();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
